// File: rtl/pc_fetch_if.sv
// Instruction-ROM read channel: registered request/address out, ack/data back.
interface pc_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              romReq;
  logic [ADDR_W-1:0] romAddr;
  logic              romAck;
  logic [DATA_W-1:0] romData;

  modport master (output romReq, output romAddr, input romAck, input romData);
  modport slave  (input romReq, input romAddr, output romAck, output romData);
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, issues ROM reads, buffers returned
// instructions in a 2-entry in-order queue and presents the head to IF/ID.
module pc_fetch #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              enable,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchAddr,
  pc_fetch_if.master        rom,
  output logic [ADDR_W-1:0] addrOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut
);

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic {ST_FETCH, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  redir_q, redir_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  qa_q [2];
  logic [ADDR_W-1:0]  qa_d [2];
  logic [DATA_W-1:0]  qd_q [2];
  logic [DATA_W-1:0]  qd_d [2];

  logic               ack;
  logic               consume;
  logic               push;
  logic               wr_tail;
  logic [CNT_W-1:0]   next_count;

  // State register
  always_ff @(posedge clk) begin
    if (resetIn) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      redir_q <= RESET_PC;
      count_q <= '0;
      for (int i = 0; i < 2; i++) begin
        qa_q[i] <= RESET_PC;
        qd_q[i] <= NOP_INSTR;
      end
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      redir_q <= redir_d;
      count_q <= count_d;
      for (int i = 0; i < 2; i++) begin
        qa_q[i] <= qa_d[i];
        qd_q[i] <= qd_d[i];
      end
    end
  end

  // Next-state: request/PC control, queue push/pop, redirect and drain handling
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    redir_d    = redir_q;
    count_d    = count_q;
    for (int i = 0; i < 2; i++) begin
      qa_d[i] = qa_q[i];
      qd_d[i] = qd_q[i];
    end
    ack        = req_q & rom.romAck;
    consume    = enable & (count_q != '0) & ~branchTaken;
    push       = 1'b0;
    wr_tail    = 1'b0;
    next_count = count_q;

    case (state_q)
      ST_FETCH: begin
        if (branchTaken) begin
          count_d = '0;
          if (!req_q || ack) begin
            addr_d = branchAddr;
            req_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            redir_d = branchAddr;
          end
        end else begin
          push       = ack;
          next_count = count_q + CNT_W'(push) - CNT_W'(consume);
          count_d    = next_count;
          if (consume && count_q == CNT_W'(2)) begin
            qa_d[0] = qa_q[1];
            qd_d[0] = qd_q[1];
          end
          // Push lands behind whatever survives this cycle's consume
          wr_tail = (count_q == CNT_W'(1)) && !consume;
          if (push) begin
            qa_d[wr_tail] = addr_q;
            qd_d[wr_tail] = rom.romData;
            addr_d        = addr_q + ADDR_W'(PC_STEP);
          end
          req_d = (req_q & ~ack) | (next_count <= CNT_W'(1));
        end
      end
      ST_DRAIN: begin
        if (branchTaken) redir_d = branchAddr;
        if (ack) begin
          state_d = ST_FETCH;
          addr_d  = branchTaken ? branchAddr : redir_q;
          req_d   = 1'b1;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign rom.romReq  = req_q;
  assign rom.romAddr = addr_q;
  assign addrOut     = qa_q[0];
  assign dataOut     = (count_q == '0) ? NOP_INSTR : qd_q[0];
  assign validOut    = (count_q != '0);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: streaming, stall, redirects, reset and PC wrap.
module tb_pc_fetch;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] XK     = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        enable;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        ack_auto;
  logic        ack_manual;
  logic [31:0] addrOut, dataOut;
  logic        validOut;
  logic [31:0] w_addrOut, w_dataOut;
  logic        w_validOut;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_if ();
  pc_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wrap_if ();

  // ROM model: data is address xor a constant, ack either tied to req or manual
  assign rom_if.romAck   = ack_auto ? rom_if.romReq : ack_manual;
  assign rom_if.romData  = rom_if.romAddr ^ XK;
  assign wrap_if.romAck  = wrap_if.romReq;
  assign wrap_if.romData = wrap_if.romAddr ^ XK;

  pc_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h0),
             .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .resetIn(resetIn), .enable(enable), .branchTaken(branchTaken),
    .branchAddr(branchAddr), .rom(rom_if.master), .addrOut(addrOut),
    .dataOut(dataOut), .validOut(validOut));

  pc_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'hFFFFFFFC),
             .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .resetIn(resetIn), .enable(1'b1), .branchTaken(1'b0),
    .branchAddr(32'h0), .rom(wrap_if.master), .addrOut(w_addrOut),
    .dataOut(w_dataOut), .validOut(w_validOut));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
  endtask

  task automatic test_reset();
    resetIn = 1'b1; enable = 1'b1; branchTaken = 1'b0; branchAddr = '0;
    ack_auto = 1'b1; ack_manual = 1'b0;
    tick(); tick();
    n_cmp++; if (rom_if.romReq !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", rom_if.romReq); end
    n_cmp++; if (rom_if.romAddr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000000", rom_if.romAddr); end
    n_cmp++; if (validOut !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", validOut); end
    n_cmp++; if (dataOut !== NOP) begin n_bad++; $display("FAIL reset_data: got %h want %h", dataOut, NOP); end
    n_cmp++; if (addrOut !== 32'h0) begin n_bad++; $display("FAIL reset_addrout: got %h want 00000000", addrOut); end
    n_cmp++; if (wrap_if.romAddr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL reset_wrap_addr: got %h want fffffffc", wrap_if.romAddr); end
  endtask

  task automatic test_stream();
    ack_auto = 1'b1; enable = 1'b1;
    do_reset();
    tick();
    n_cmp++; if (rom_if.romReq !== 1'b1 || rom_if.romAddr !== 32'h0) begin n_bad++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=00000000", rom_if.romReq, rom_if.romAddr); end
    n_cmp++; if (validOut !== 1'b0) begin n_bad++; $display("FAIL stream_first_valid: got %b want 0", validOut); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (rom_if.romAddr !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, rom_if.romAddr, 32'(4 * i)); end
      n_cmp++; if (validOut !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, validOut); end
      n_cmp++; if (addrOut !== 32'(4 * (i - 1))) begin n_bad++; $display("FAIL stream_head_addr[%0d]: got %h want %h", i, addrOut, 32'(4 * (i - 1))); end
      n_cmp++; if (dataOut !== (32'(4 * (i - 1)) ^ XK)) begin n_bad++; $display("FAIL stream_head_data[%0d]: got %h want %h", i, dataOut, 32'(4 * (i - 1)) ^ XK); end
    end
  endtask

  task automatic test_stall();
    ack_auto = 1'b1; enable = 1'b0;
    do_reset();
    tick(); tick(); tick();
    n_cmp++; if (rom_if.romReq !== 1'b0 || rom_if.romAddr !== 32'h8) begin n_bad++; $display("FAIL stall_req_drop: got req=%b addr=%h want req=0 addr=00000008", rom_if.romReq, rom_if.romAddr); end
    tick();
    n_cmp++; if (rom_if.romReq !== 1'b0 || rom_if.romAddr !== 32'h8) begin n_bad++; $display("FAIL stall_hold: got req=%b addr=%h want req=0 addr=00000008", rom_if.romReq, rom_if.romAddr); end
    n_cmp++; if (validOut !== 1'b1 || addrOut !== 32'h0 || dataOut !== XK) begin n_bad++; $display("FAIL stall_head0: got v=%b a=%h d=%h want v=1 a=00000000 d=%h", validOut, addrOut, dataOut, XK); end
    enable = 1'b1;
    tick();
    n_cmp++; if (addrOut !== 32'h4 || dataOut !== (32'h4 ^ XK)) begin n_bad++; $display("FAIL stall_head4: got a=%h d=%h want a=00000004 d=%h", addrOut, dataOut, 32'h4 ^ XK); end
    n_cmp++; if (rom_if.romReq !== 1'b1 || rom_if.romAddr !== 32'h8) begin n_bad++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=00000008", rom_if.romReq, rom_if.romAddr); end
    tick();
    n_cmp++; if (addrOut !== 32'h8 || rom_if.romAddr !== 32'hC) begin n_bad++; $display("FAIL stall_after: got head=%h romAddr=%h want head=00000008 romAddr=0000000c", addrOut, rom_if.romAddr); end
  endtask

  task automatic test_branch_ack();
    ack_auto = 1'b1; enable = 1'b1;
    do_reset();
    tick(); tick(); tick();
    branchTaken = 1'b1; branchAddr = 32'h100;
    tick();
    branchTaken = 1'b0;
    n_cmp++; if (validOut !== 1'b0 || dataOut !== NOP) begin n_bad++; $display("FAIL br_flush: got v=%b d=%h want v=0 d=%h", validOut, dataOut, NOP); end
    n_cmp++; if (rom_if.romReq !== 1'b1 || rom_if.romAddr !== 32'h100) begin n_bad++; $display("FAIL br_target: got req=%b addr=%h want req=1 addr=00000100", rom_if.romReq, rom_if.romAddr); end
    n_cmp++; if (addrOut !== 32'h4) begin n_bad++; $display("FAIL br_addr_hold: got %h want 00000004", addrOut); end
    tick();
    n_cmp++; if (validOut !== 1'b1 || addrOut !== 32'h100 || dataOut !== (32'h100 ^ XK)) begin n_bad++; $display("FAIL br_first: got v=%b a=%h d=%h want v=1 a=00000100 d=%h", validOut, addrOut, dataOut, 32'h100 ^ XK); end
    n_cmp++; if (rom_if.romAddr !== 32'h104) begin n_bad++; $display("FAIL br_next: got %h want 00000104", rom_if.romAddr); end
  endtask

  task automatic test_branch_drain();
    ack_auto = 1'b0; ack_manual = 1'b0; enable = 1'b1;
    do_reset();
    tick();
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    n_cmp++; if (validOut !== 1'b1 || rom_if.romAddr !== 32'h4) begin n_bad++; $display("FAIL dr_setup: got v=%b addr=%h want v=1 addr=00000004", validOut, rom_if.romAddr); end
    branchTaken = 1'b1; branchAddr = 32'h200;
    tick();
    branchTaken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rom_if.romReq !== 1'b1 || rom_if.romAddr !== 32'h4 || validOut !== 1'b0) begin n_bad++; $display("FAIL dr_hold[%0d]: got req=%b addr=%h v=%b want req=1 addr=00000004 v=0", i, rom_if.romReq, rom_if.romAddr, validOut); end
      if (i < 2) tick();
    end
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    n_cmp++; if (rom_if.romReq !== 1'b1 || rom_if.romAddr !== 32'h200 || validOut !== 1'b0) begin n_bad++; $display("FAIL dr_redirect: got req=%b addr=%h v=%b want req=1 addr=00000200 v=0", rom_if.romReq, rom_if.romAddr, validOut); end
    tick();
    n_cmp++; if (validOut !== 1'b0) begin n_bad++; $display("FAIL dr_wait: got %b want 0", validOut); end
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    n_cmp++; if (validOut !== 1'b1 || addrOut !== 32'h200 || dataOut !== (32'h200 ^ XK)) begin n_bad++; $display("FAIL dr_first: got v=%b a=%h d=%h want v=1 a=00000200 d=%h", validOut, addrOut, dataOut, 32'h200 ^ XK); end
    n_cmp++; if (rom_if.romAddr !== 32'h204) begin n_bad++; $display("FAIL dr_next: got %h want 00000204", rom_if.romAddr); end
  endtask

  task automatic test_reset_midflight();
    ack_auto = 1'b1; enable = 1'b1;
    do_reset();
    tick();
    branchTaken = 1'b1; branchAddr = 32'h300;
    tick();
    branchTaken = 1'b0; enable = 1'b0;
    tick(); tick();
    n_cmp++; if (validOut !== 1'b1 || addrOut !== 32'h300 || rom_if.romReq !== 1'b0) begin n_bad++; $display("FAIL mid_full: got v=%b a=%h req=%b want v=1 a=00000300 req=0", validOut, addrOut, rom_if.romReq); end
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    n_cmp++; if (validOut !== 1'b0 || rom_if.romReq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_vr: got v=%b req=%b want v=0 req=0", validOut, rom_if.romReq); end
    n_cmp++; if (dataOut !== NOP || addrOut !== 32'h0 || rom_if.romAddr !== 32'h0) begin n_bad++; $display("FAIL mid_reset_out: got d=%h a=%h romAddr=%h want d=%h a=00000000 romAddr=00000000", dataOut, addrOut, rom_if.romAddr, NOP); end
    tick();
    n_cmp++; if (rom_if.romReq !== 1'b1 || validOut !== 1'b0) begin n_bad++; $display("FAIL mid_restart: got req=%b v=%b want req=1 v=0", rom_if.romReq, validOut); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_cmp++; if (wrap_if.romAddr !== 32'hFFFFFFFC || wrap_if.romReq !== 1'b1) begin n_bad++; $display("FAIL wrap_first: got req=%b addr=%h want req=1 addr=fffffffc", wrap_if.romReq, wrap_if.romAddr); end
    tick();
    n_cmp++; if (wrap_if.romAddr !== 32'h0 || w_addrOut !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_zero: got addr=%h head=%h want addr=00000000 head=fffffffc", wrap_if.romAddr, w_addrOut); end
    tick();
    n_cmp++; if (wrap_if.romAddr !== 32'h4 || w_addrOut !== 32'h0 || w_validOut !== 1'b1 || w_dataOut !== XK) begin n_bad++; $display("FAIL wrap_after: got addr=%h head=%h v=%b d=%h want addr=00000004 head=00000000 v=1 d=%h", wrap_if.romAddr, w_addrOut, w_validOut, w_dataOut, XK); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_ack();
    test_branch_drain();
    test_reset_midflight();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues instruction-ROM reads over a req/ack handshake.
- Buffers returned instructions in a 2-entry in-order queue and presents the queue head (PC + instruction) to IF/ID.
- Honours the hazard-unit stall (enable) and branch redirects from downstream, discarding wrong-path fetches.

Parameters:
ADDR_W, 32, ROM address / PC width
DATA_W, 32, instruction width
RESET_PC, 0, PC of the first fetch after reset
NOP_INSTR, 32'h00000013, instruction driven on dataOut while the queue is empty

Ports:
clk  in  1  clock, all state updates on posedge
resetIn  in  1  synchronous, active-high reset
enable  in  1  from hazard detect unit; 1 = IF/ID consumes the head this cycle, 0 = hold
branchTaken  in  1  redirect request, single-cycle pulse
branchAddr  in  ADDR_W  redirect target, valid with branchTaken
romReq  out  1  registered ROM read request
romAddr  out  ADDR_W  registered ROM read address
romAck  in  1  ROM read complete; romData valid this cycle; sampled only while romReq=1
romData  in  DATA_W  instruction from ROM
addrOut  out  ADDR_W  PC of queue head, to IF/ID addrIn
dataOut  out  DATA_W  queue-head instruction, or NOP_INSTR when empty, to IF/ID dataIn
validOut  out  1  queue non-empty

Behaviour:
- Reset (resetIn=1 at posedge):
  - count=0, romReq=0, romAddr=RESET_PC, discard=0.
  - Queue entries cleared: addr=RESET_PC, data=NOP_INSTR.
  - Outputs: validOut=0, dataOut=NOP_INSTR, addrOut=RESET_PC.
  - Reset overrides everything, including an outstanding ROM request. The ROM is reset by the same resetIn.
- Handshake:
  - Once romReq=1, romReq and romAddr stay stable until the cycle romAck=1.
  - At most one request is outstanding.
  - romAck while romReq=0 is ignored.
- Queue: 2-entry FIFO (head, tail). count ranges 0..2.
  - consume = enable & (count!=0) & ~branchTaken.
  - Head outputs are combinational from the head register. dataOut is forced to NOP_INSTR when count==0.
  - addrOut holds the last head address when count==0.
- Normal fetch (no redirect, discard=0):
  - On romReq&romAck: push {romAddr, romData}; romAddr <= romAddr+4.
  - Let nextCount = count + push - consume. The request logic never lets nextCount exceed 2.
  - romReq_next = (nextCount <= 1). Back-to-back requests are allowed, giving one instruction per cycle when the ROM acks immediately.
  - When romReq=0 and not reset, romReq rises at the next edge once nextCount <= 1.
- Redirect (branchTaken=1, priority over enable/consume):
  - Queue flushed: count <= 0.
  - If romReq=0, or romReq&romAck: the acked data is dropped; romAddr <= branchAddr, romReq <= 1.
  - If romReq=1 & romAck=0: enter DRAIN (discard=1) and latch redirectPc <= branchAddr. romReq/romAddr stay held.
- DRAIN state:
  - On romAck, the data is dropped: discard <= 0, romAddr <= redirectPc, romReq <= 1.
  - A further branchTaken in DRAIN only updates redirectPc.
  - validOut stays 0 throughout.
- Arithmetic:
  - PC increment is +4, modulo 2^ADDR_W; wraps silently.
  - No alignment checking; branchAddr is used as given.
- Simultaneous events:
  - Push and consume in the same cycle with count=1: count stays 1, and the new entry becomes head.
  - Push and consume with count=2: cannot occur, because no request is issued at count=2.
  - Stall with count=2: romReq=0 and all outputs hold.
- Latency: from the first edge with resetIn=0, romReq=1 and romAddr=RESET_PC. With an immediate ack, validOut=1 after the next edge.

Test Plan:
- Reset, then romAck tied to romReq, enable=1, RESET_PC=0 -> romAddr sequence 0,4,8,C on consecutive cycles; validOut=1 from the second post-reset cycle; addrOut/dataOut follow the same sequence one cycle behind.
- Same as above but enable=0 from cycle 2 -> count reaches 2 (entries 0,4), romReq drops with romAddr=8 held; enable=1 -> heads 0 then 4 presented in order and fetching resumes at 8.
- branchTaken=1, branchAddr=0x100 in a cycle with romAck=1 for addr 8 -> queue empties (validOut=0, dataOut=0x00000013), romAddr=0x100 next cycle, and addr 8 is never presented.
- branchTaken=1, branchAddr=0x200 while romReq=1 and ack delayed 3 cycles -> romReq/romAddr held; returned data discarded; next romAddr=0x200; validOut=0 until 0x200 returns.
- resetIn=1 for one cycle with count=2 and a request pending -> next cycle count=0, romReq=0, validOut=0, dataOut=NOP_INSTR, addrOut=RESET_PC.
- RESET_PC=32'hFFFFFFFC with immediate acks -> romAddr FFFFFFFC then 00000000.
